// File: rtl/gen_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : gen_fifo_wr_arb
// Purpose  : Round-robin write arbiter sharing one FIFO write port between
//            N_REQ valid/ready producers, granting bursts of up to MAX_BURST
//            beats and never pushing into a full FIFO.
// Options  : GEN_FIFO_WR_ARB_AF_THROTTLE_EN - when defined, no new burst is
//            granted while the FIFO reports almost-full.
// Revision : 1.0 - initial release
// ============================================================================
module gen_fifo_wr_arb #(
  parameter  int N_REQ     = 4,
  parameter  int DAT_W     = 4,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int BST_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*DAT_W-1:0] req_dat,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic                   fifo_full,
  input  logic                   fifo_af,
  output logic                   fifo_push,
  output logic [DAT_W-1:0]       fifo_dat,
  output logic                   sts_busy,
  output logic [IDX_W-1:0]       sts_gnt_idx
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_prio,  w_prio_nxt;
  logic [BST_W-1:0]   r_bcnt,  w_bcnt_nxt;

  logic [DAT_W-1:0]   w_dat_arr [N_REQ];
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_owner_inc;
  logic               w_gate;
  logic               w_in_burst;
  logic               w_own_vld;
  logic               w_beat;
  logic               w_last;

  // Split the flat data bus into one slot per requester
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_dat_arr[gi] = req_dat[gi*DAT_W +: DAT_W];
  end

`ifdef GEN_FIFO_WR_ARB_AF_THROTTLE_EN
  assign w_gate = ~fifo_af;
`else
  logic w_unused_af;
  assign w_unused_af = fifo_af;
  assign w_gate      = 1'b1;
`endif

  // clr masks the whole transfer path in its cycle
  assign w_in_burst  = (r_state == ST_BURST) & ~clr;
  assign w_own_vld   = req_vld[r_owner];
  assign w_beat      = w_in_burst & w_own_vld & ~fifo_full;
  assign w_last      = w_beat & ((r_bcnt + BST_W'(1)) == BST_W'(MAX_BURST));
  // explicit wrap so a non-power-of-2 N_REQ never selects a missing slot
  assign w_owner_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Round-robin pick: scan from highest offset down so the lowest offset from prio wins
  always_comb begin
    w_sel  = '0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(r_prio) + k) % N_REQ);
      if (req_vld[w_cand]) begin
        w_sel = w_cand;
      end
    end
  end

  // Handshake outputs toward the producers and the FIFO
  always_comb begin
    req_rdy   = '0;
    fifo_push = w_beat;
    fifo_dat  = '0;
    if (w_in_burst) begin
      req_rdy[r_owner] = ~fifo_full;
    end
    if (w_beat) begin
      fifo_dat = w_dat_arr[r_owner];
    end
  end

  // Next-state: grant in IDLE, count beats and detect burst end in BURST
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_bcnt_nxt  = r_bcnt;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_prio_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((|req_vld) && w_gate) begin
            w_state_nxt = ST_BURST;
            w_owner_nxt = w_sel;
            w_bcnt_nxt  = '0;
          end
        end
        ST_BURST: begin
          if (w_beat) begin
            w_bcnt_nxt = r_bcnt + BST_W'(1);
          end
          if (w_last || !w_own_vld) begin
            w_state_nxt = ST_IDLE;
            w_prio_nxt  = w_owner_inc;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_prio  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  assign sts_busy    = (r_state == ST_BURST);
  assign sts_gnt_idx = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_gen_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_fifo_wr_arb
// Purpose  : Self-checking bench for gen_fifo_wr_arb; directed scenarios plus
//            randomized traffic compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_dat;
  logic [N-1:0]    req_rdy;
  logic            fifo_full;
  logic            fifo_af;
  logic            fifo_push;
  logic [DW-1:0]   fifo_dat;
  logic            sts_busy;
  logic [IW-1:0]   sts_gnt_idx;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model of the arbiter: which producer holds the grant and how far its burst has got
  bit m_busy;
  int m_owner;
  int m_prio;
  int m_beats;

  logic obs_push;
  int   push_tot;

  gen_fifo_wr_arb #(.N_REQ(N), .DAT_W(DW), .MAX_BURST(MB)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .req_vld    (req_vld),
    .req_dat    (req_dat),
    .req_rdy    (req_rdy),
    .fifo_full  (fifo_full),
    .fifo_af    (fifo_af),
    .fifo_push  (fifo_push),
    .fifo_dat   (fifo_dat),
    .sts_busy   (sts_busy),
    .sts_gnt_idx(sts_gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_prio  = 0;
    m_beats = 0;
  endtask

  function automatic bit grant_open();
`ifdef GEN_FIFO_WR_ARB_AF_THROTTLE_EN
    return !fifo_af;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: inputs already driven after a falling edge; check, clock, advance the model
  task automatic step();
    logic [N-1:0]  e_rdy;
    logic          e_push;
    logic [DW-1:0] e_dat;
    bit            beat;
    #1;
    e_rdy  = '0;
    e_push = 1'b0;
    e_dat  = '0;
    beat   = 1'b0;
    if (m_busy && !clr) begin
      e_rdy[m_owner] = !fifo_full;
      if (req_vld[m_owner] && !fifo_full) begin
        beat   = 1'b1;
        e_push = 1'b1;
        e_dat  = req_dat[m_owner*DW +: DW];
      end
    end
    obs_push = fifo_push;
    if (fifo_push === 1'b1) push_tot++;
    chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
    chk("fifo_push", 32'(fifo_push), 32'(e_push));
    chk("fifo_dat", 32'(fifo_dat), 32'(e_dat));
    chk("sts_busy", 32'(sts_busy), 32'(m_busy));
    chk("sts_gnt_idx", 32'(sts_gnt_idx), 32'(m_owner));
    @(posedge clk);
    if (clr) begin
      m_busy = 1'b0;
      m_prio = 0;
    end else if (!m_busy) begin
      if (req_vld != '0 && grant_open()) begin
        for (int k = 0; k < N; k++) begin
          if (req_vld[(m_prio + k) % N]) begin
            m_owner = (m_prio + k) % N;
            break;
          end
        end
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end else begin
      if (beat) m_beats++;
      if (!req_vld[m_owner] || m_beats == MB) begin
        m_busy = 1'b0;
        m_prio = (m_owner + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  // Return to IDLE with the priority pointer at 0
  task automatic go_idle();
    req_vld   = '0;
    fifo_full = 1'b0;
    fifo_af   = 1'b0;
    clr       = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  initial begin
    logic [9:0] pat;
    rst_n     = 1'b0;
    clr       = 1'b0;
    req_vld   = '0;
    req_dat   = '0;
    fifo_full = 1'b0;
    fifo_af   = 1'b0;
    model_reset();

    // Reset values with requests present
    req_vld = 4'b1111;
    req_dat = 16'hA5C3;
    #2;
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_push", 32'(fifo_push), 32'h0);
    chk("rst_dat", 32'(fifo_dat), 32'h0);
    chk("rst_busy", 32'(sts_busy), 32'h0);
    chk("rst_gnt", 32'(sts_gnt_idx), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: 4 beats then one bubble
    req_vld = 4'b0001;
    pat     = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      req_dat = 16'($urandom);
      step();
      chk("single_pat", 32'(obs_push), 32'(pat[i]));
    end

    // All requesters: round-robin 0,1,2,3,0
    go_idle();
    req_vld = 4'b1111;
    for (int i = 0; i < 26; i++) begin
      req_dat = 16'($urandom);
      step();
    end

    // Requester 2 stalled by full after its 2nd beat
    go_idle();
    req_vld  = 4'b0100;
    push_tot = 0;
    for (int i = 0; i < 3; i++) begin
      req_dat = 16'($urandom);
      step();
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_dat = 16'($urandom);
      step();
      chk("full_rdy2", 32'(req_rdy[2]), 32'h0);
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_dat = 16'($urandom);
      step();
    end
    req_vld = '0;
    step();
    chk("full_pushes", 32'(push_tot), 32'd4);

    // Requester 1 drops after 2 beats, requester 3 takes over
    go_idle();
    req_vld = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      req_dat = 16'($urandom);
      step();
    end
    req_vld = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      req_dat = 16'($urandom);
      step();
    end
    chk("drop_owner3", 32'(sts_gnt_idx), 32'd3);

    // clr during the 2nd beat of requester 1
    go_idle();
    req_vld = 4'b0110;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("clr_regrant1", 32'(sts_gnt_idx), 32'd1);

    // Almost-full while idle
    go_idle();
    fifo_af = 1'b1;
    req_vld = 4'b0100;
    for (int i = 0; i < 3; i++) step();
    fifo_af = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset in the middle of a burst
    go_idle();
    req_vld = 4'b1111;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_push", 32'(fifo_push), 32'h0);
    chk("arst_rdy", 32'(req_rdy), 32'h0);
    chk("arst_busy", 32'(sts_busy), 32'h0);
    chk("arst_gnt", 32'(sts_gnt_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    req_vld = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5, 0) == 0) req_vld[b] = ~req_vld[b];
      end
      req_dat   = 16'($urandom);
      fifo_full = ($urandom_range(4, 0) == 0);
      fifo_af   = ($urandom_range(3, 0) == 0);
      clr       = ($urandom_range(39, 0) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gen_fifo_wr_arb.md
# gen_fifo_wr_arb

Round-robin write arbiter that shares one `gen_fifo_top` instance between `N_REQ` producers. Each producer offers data on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` beats and drives the FIFO `push`/`dat_in` pins. It never pushes into a full FIFO. It sits directly in front of the FIFO write side; the pop side is untouched.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2
- `DAT_W`, 4: data width [bits], must equal the FIFO `DAT_W`
- `MAX_BURST`, 4: maximum beats per grant, ≥1
- `IDX_W`, localparam `$clog2(N_REQ)`: grant index width
- `BST_W`, localparam `$clog2(MAX_BURST+1)`: burst counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async reset, active low
- `clr`  in  1  synchronous abort: return to IDLE, priority pointer to 0
- `req_vld`  in  N_REQ  per-requester valid
- `req_dat`  in  N_REQ*DAT_W  per-requester data; requester i occupies bits [i*DAT_W +: DAT_W]
- `req_rdy`  out  N_REQ  per-requester ready, one-hot or zero
- `fifo_full`  in  1  FIFO `sts_full`
- `fifo_af`  in  1  FIFO `sts_af`
- `fifo_push`  out  1  to FIFO `push`
- `fifo_dat`  out  DAT_W  to FIFO `dat_in`
- `sts_busy`  out  1  state is BURST
- `sts_gnt_idx`  out  IDX_W  current or last owner index

## Operation
- States: IDLE and BURST. Registers: `state`, `owner` (IDX_W), `prio` (IDX_W), `bcnt` (BST_W).
- IDLE:
  - If `|req_vld` and the grant gate is open, pick the first requester with `req_vld` set, scanning `prio`, `prio+1`, … modulo `N_REQ`.
  - Load `owner` with it, clear `bcnt`, and go to BURST.
  - No transfer happens in IDLE.
- BURST:
  - `req_rdy[owner] = ~fifo_full`; all other `req_rdy` bits are 0.
  - A beat occurs when `req_vld[owner] & req_rdy[owner]`. On a beat: `fifo_push=1`, `fifo_dat=req_dat[owner]`, and `bcnt` increments.
  - The burst ends and the state returns to IDLE when either:
    - (a) the beat just made brings `bcnt+1 == MAX_BURST`, or
    - (b) `req_vld[owner]` is 0 in this cycle.
  - On burst end, `prio <= owner+1` (wraps at `N_REQ`; a non-power-of-2 `N_REQ` wraps explicitly).
  - While `fifo_full` is high with valid still asserted, the arbiter stalls in BURST: no push, no count change, no end.
- `fifo_push` is combinational from state, owner, `req_vld` and `fifo_full`. It is never 1 when `fifo_full=1`, so the FIFO overflow error cannot be raised by this block.
- `clr` has priority over all transitions. In the `clr` cycle, no push and all `req_rdy` are 0.
- Outside BURST: `fifo_dat` is 0 and `req_rdy` is 0.

## Timing
- Reset values: `state` = IDLE, `owner` = 0, `prio` = 0, `bcnt` = 0. Outputs: `req_rdy` = 0, `fifo_push` = 0, `fifo_dat` = 0, `sts_busy` = 0, `sts_gnt_idx` = 0.
- Arbitration latency: `req_vld` rising in IDLE gives the first possible beat on the next cycle.
- A back-to-back burst from another requester costs exactly one IDLE bubble cycle between bursts.
- Reset asserted mid-burst: all state clears immediately (asynchronously). A beat in flight at reset is not pushed.
- A requester may drop `req_vld` at any cycle. The drop ends its burst in that same cycle.
- Single requester continuously valid, `MAX_BURST`=4: pattern is 4 beats then 1 bubble, repeating.

## Configuration
- `GEN_FIFO_WR_ARB_AF_THROTTLE_EN`:
  - Defined: the IDLE grant gate is `~fifo_af`, so no new burst starts while the FIFO is almost-full. Bursts already in BURST continue until `fifo_full`.
  - Undefined: the grant gate is always open and `fifo_af` is ignored. The port stays present and unused.

## Test plan
- Reset, then `req_vld`=4'b0001 continuous, `MAX_BURST`=4, FIFO empty → `fifo_push` pattern 0,1,1,1,1,0,1,1,1,1; `sts_gnt_idx`=0 throughout.
- `req_vld`=4'b1111 continuous, FIFO drained each cycle → owners 0,1,2,3,0 in order, 4 beats each, one bubble between bursts; `req_rdy` one-hot matching the owner.
- Requester 2 alone, `fifo_full` forced to 1 for 3 cycles after the 2nd beat → no push and `req_rdy[2]`=0 for those 3 cycles, then the remaining 2 beats complete; total pushes 4.
- Requester 1 drops `req_vld` after 2 beats while requester 3 is valid → burst ends with `bcnt`=2, IDLE for 1 cycle, grant goes to 3, `prio` becomes 2 then 0.
- `clr` pulsed during beat 2 of requester 1 → no push that cycle, next cycle IDLE with `prio`=0, and the following grant goes to the lowest valid index.
- With `GEN_FIFO_WR_ARB_AF_THROTTLE_EN` defined and `fifo_af`=1 in IDLE, `req_vld`=4'b0100 → no grant until `fifo_af`=0, then grant to 2 on the next cycle. With the macro undefined, the grant is immediate.
